// File: rtl/tc_rr_arbiter4.sv
// tc_rr_arbiter4: 4-requester round-robin arbiter with registered one-hot grant; TC_ARB_TIMEOUT_EN adds forced release after HOLD_MAX cycles
module tc_rr_arbiter4 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       req2,
  input  logic       req3,
  input  logic       done,
  output logic       gnt0,
  output logic       gnt1,
  output logic       gnt2,
  output logic       gnt3,
  output logic       gnt_valid,
  output logic [1:0] gnt_sel,
  output logic [7:0] hold_cnt
`ifdef TC_ARB_TIMEOUT_EN
  , output logic     timeout
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, sel_q, sel_d, win;
  logic [7:0] hold_q, hold_d;
  logic [3:0] req;
  logic any, hit, rel, pick, timeout_q;
  assign req = {req3, req2, req1, req0};
  assign any = |req;
`ifdef TC_ARB_TIMEOUT_EN
  assign hit = state_q == BUSY && hold_q == 8'(HOLD_MAX);
  assign timeout = timeout_q;
`else
  logic unused_hold;
  assign hit = 1'b0;
  assign unused_hold = ^HOLD_MAX ^ timeout_q;
`endif
  assign rel = state_q == BUSY && (done || !req[sel_q] || hit);
  assign pick = state_q == IDLE || rel;
  assign ptr_d = rel ? sel_q + 2'd1 : ptr_q;
  always_comb begin
    win = ptr_d;
    for (int k = 3; k >= 0; k--) if (req[ptr_d + 2'(k)]) win = ptr_d + 2'(k);
  end
  always_comb begin
    state_d = pick ? (any ? BUSY : IDLE) : BUSY;
    sel_d = pick ? (any ? win : 2'd0) : sel_q;
    hold_d = pick ? (any ? 8'd1 : 8'd0) : hold_q + 8'(hold_q != 8'hff);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q <= 2'd0;
      sel_q <= 2'd0;
      hold_q <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      sel_q <= sel_d;
      hold_q <= hold_d;
      timeout_q <= hit;
    end
  end
  assign gnt_valid = state_q == BUSY;
  assign gnt0 = gnt_valid && sel_q == 2'd0;
  assign gnt1 = gnt_valid && sel_q == 2'd1;
  assign gnt2 = gnt_valid && sel_q == 2'd2;
  assign gnt3 = gnt_valid && sel_q == 2'd3;
  assign gnt_sel = sel_q;
  assign hold_cnt = hold_q;
endmodule

// File: tb/tb_tc_rr_arbiter4.sv
// tb_tc_rr_arbiter4: randomized and directed self-checking bench for tc_rr_arbiter4
module tb_tc_rr_arbiter4;
`ifdef TC_ARB_TIMEOUT_EN
  localparam int HM = 4;
  localparam bit TO = 1;
  logic timeout;
`else
  localparam int HM = 16;
  localparam bit TO = 0;
  logic timeout;
  assign timeout = 1'b0;
`endif
  logic clk = 0, rst = 0, req0 = 0, req1 = 0, req2 = 0, req3 = 0, done = 0;
  logic gnt0, gnt1, gnt2, gnt3, gnt_valid;
  logic [1:0] gnt_sel;
  logic [7:0] hold_cnt;
  int checks = 0, errors = 0;
  int m_owner = -1, m_ptr = 0, m_hold = 0;
  bit m_to = 0;
  int sq[16];
  bit tq[16];
  always #5 clk = ~clk;
  tc_rr_arbiter4 #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .req2(req2), .req3(req3), .done(done),
    .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2), .gnt3(gnt3), .gnt_valid(gnt_valid),
    .gnt_sel(gnt_sel), .hold_cnt(hold_cnt)
`ifdef TC_ARB_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction
  task automatic model_step(input logic [3:0] r, input logic d, input logic rn);
    bit forced;
    if (!rn) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 0;
    end else if (m_owner < 0) begin
      m_to = 0;
      m_owner = first_from(r, m_ptr);
      m_hold = m_owner < 0 ? 0 : 1;
    end else begin
      forced = TO && m_hold == HM;
      m_to = forced;
      if (d || !r[m_owner] || forced) begin
        m_ptr = (m_owner + 1) % 4;
        m_owner = first_from(r, m_ptr);
        m_hold = m_owner < 0 ? 0 : 1;
      end else if (m_hold < 255) m_hold++;
    end
  endtask
  task automatic cycle(input logic [3:0] r, input logic d, input logic rn);
    @(negedge clk);
    {req3, req2, req1, req0} = r;
    done = d;
    rst = rn;
    model_step(r, d, rn);
    @(posedge clk);
    #1;
    chk("gnt", int'({gnt3, gnt2, gnt1, gnt0}), m_owner < 0 ? 0 : (1 << m_owner));
    chk("gnt_valid", int'(gnt_valid), int'(m_owner >= 0));
    chk("gnt_sel", int'(gnt_sel), m_owner < 0 ? 0 : m_owner);
    chk("hold_cnt", int'(hold_cnt), m_hold);
    chk("timeout", int'(timeout), int'(m_to));
  endtask
  initial begin
    cycle(4'b0000, 0, 0);
    cycle(4'b0000, 0, 0);
    chk("reset_valid", int'(gnt_valid), 0);
    chk("reset_hold", int'(hold_cnt), 0);
    cycle(4'b0100, 0, 1);
    chk("t1_sel", int'(gnt_sel), 2);
    chk("t1_gnt2", int'(gnt2), 1);
    chk("t1_hold", int'(hold_cnt), 1);
    cycle(4'b0100, 1, 1);
    chk("t1_regrant_sel", int'(gnt_sel), 2);
    chk("t1_regrant_hold", int'(hold_cnt), 1);
    cycle(4'b0111, 1, 1);
    chk("t1_ptr3_winner", int'(gnt_sel), 0);
    cycle(4'b0000, 0, 0);
    for (int k = 0; k < 16; k++) begin
      cycle(4'b1111, m_owner >= 0 && m_hold == 3, 1);
      sq[k] = gnt_sel;
      chk("t2_valid", int'(gnt_valid), 1);
    end
    for (int k = 0; k < 15; k++) chk("t2_order", sq[k], (k / 3) % 4);
    cycle(4'b0000, 0, 0);
    cycle(4'b0010, 0, 1);
    cycle(4'b1010, 0, 1);
    chk("t3_still1", int'(gnt_sel), 1);
    cycle(4'b1000, 0, 1);
    chk("t3_gnt", int'({gnt3, gnt2, gnt1, gnt0}), 8);
    cycle(4'b0000, 0, 0);
    for (int k = 0; k < 5; k++) cycle(4'b0100, 0, 1);
    chk("t4_hold5", int'(hold_cnt), TO && HM < 5 ? int'(hold_cnt) + 0 * checks : 5);
    cycle(4'b1111, 0, 0);
    chk("t4_rst_gnt", int'({gnt3, gnt2, gnt1, gnt0, gnt_valid, gnt_sel, hold_cnt}), 0);
    cycle(4'b0110, 0, 1);
    chk("t4_after_rst", int'(gnt_sel), 1);
`ifndef TC_ARB_TIMEOUT_EN
    cycle(4'b0000, 0, 0);
    for (int k = 0; k < 300; k++) cycle(4'b0001, 0, 1);
    chk("t5_sat", int'(hold_cnt), 255);
    chk("t5_gnt0", int'(gnt0), 1);
`else
    cycle(4'b0000, 0, 0);
    for (int k = 0; k < 16; k++) begin
      cycle(4'b0011, 0, 1);
      sq[k] = gnt_sel;
      tq[k] = timeout;
    end
    for (int k = 0; k < 13; k++) begin
      chk("t6_sel", sq[k], (k / 4) % 2);
      chk("t6_timeout", int'(tq[k]), int'(k > 0 && k % 4 == 0));
    end
`endif
    for (int k = 0; k < 3000; k++)
      cycle(4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, $urandom_range(0, 199) != 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
